// File: rtl/delay_cycle.sv
// rtl/delay_cycle.sv - programmable start-to-done delay timer
// Captures a length on start, runs it down, then emits a one-cycle done pulse.
module delay_cycle #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] times,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] load_val;

  // A zero length is treated as one cycle, so the reload never underflows.
  always_comb begin
    load_val = (times == '0) ? '0 : times - WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // COUNT never looks at start, so unknown start values cannot disturb a run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COUNT;
          cnt_d   = load_val;
        end
      end
      COUNT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WIDTH'(1);
        end else begin
          state_d = FIRE;
        end
      end
      FIRE: begin
        if (start) begin
          state_d = COUNT;
          cnt_d   = load_val;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // done trails FIRE by one cycle; busy is held off in that same cycle so
  // a back-to-back restart never overlaps the pulse.
  always_comb begin
    done_d = (state_q == FIRE);
    busy_d = (state_d == COUNT) && (state_q != FIRE);
  end

  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_delay_cycle.sv
// tb/tb_delay_cycle.sv - directed self-checking bench for delay_cycle
module tb_delay_cycle;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] times;
  logic             done;
  logic             busy;

  int tests_run;
  int tests_failed;

  delay_cycle #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .times (times),
    .done  (done),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(input logic [WIDTH-1:0] n);
    times = n;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Observes edges k+1..k+edges; smask[e] is driven on start before edge k+e.
  task automatic watch(input int edges, input logic [15:0] smask,
                       output int first_done, output int n_done,
                       output int busy_n, output int overlap,
                       output logic [31:0] done_vec);
    first_done = -1;
    n_done     = 0;
    busy_n     = 0;
    overlap    = 0;
    done_vec   = '0;
    for (int e = 1; e <= edges; e++) begin
      start = (e < 16) ? smask[e] : 1'b0;
      step();
      if (done === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = e;
        if (e < 32) done_vec[e] = 1'b1;
      end
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1 && busy === 1'b1) overlap++;
    end
    start = 1'b0;
  endtask

  task automatic settle();
    start = 1'b0;
    for (int i = 0; i < 8; i++) step();
  endtask

  int          fd, nd, bn, ov;
  logic [31:0] dv;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    start = 1'b0;
    times = '0;

    #1;
    check("reset_done", 32'(done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;

    watch(3, 16'h0000, fd, nd, bn, ov, dv);
    check("post_reset_quiet_done", 32'(nd), 32'd0);
    check("post_reset_quiet_busy", 32'(bn), 32'd0);

    // times=1
    start_pulse(8'd1);
    check("t1_busy_after_k", 32'(busy), 32'd1);
    check("t1_done_after_k", 32'(done), 32'd0);
    watch(6, 16'h0000, fd, nd, bn, ov, dv);
    check("t1_done_edge", 32'(fd), 32'd2);
    check("t1_done_count", 32'(nd), 32'd1);
    check("t1_busy_cycles", 32'(bn + 1), 32'd1);
    check("t1_overlap", 32'(ov), 32'd0);
    settle();

    // times=5
    start_pulse(8'd5);
    check("t5_busy_after_k", 32'(busy), 32'd1);
    watch(10, 16'h0000, fd, nd, bn, ov, dv);
    check("t5_done_edge", 32'(fd), 32'd6);
    check("t5_done_count", 32'(nd), 32'd1);
    check("t5_busy_cycles", 32'(bn + 1), 32'd5);
    check("t5_overlap", 32'(ov), 32'd0);
    settle();

    // times=0 behaves as times=1
    start_pulse(8'd0);
    check("t0_busy_after_k", 32'(busy), 32'd1);
    watch(6, 16'h0000, fd, nd, bn, ov, dv);
    check("t0_done_edge", 32'(fd), 32'd2);
    check("t0_done_count", 32'(nd), 32'd1);
    settle();

    // times=3, start re-pulsed at k+1 and k+2, times altered after capture
    start_pulse(8'd3);
    times = 8'd7;
    watch(10, 16'h0006, fd, nd, bn, ov, dv);
    check("repulse_done_edge", 32'(fd), 32'd4);
    check("repulse_done_count", 32'(nd), 32'd1);
    check("repulse_busy_cycles", 32'(bn + 1), 32'd3);
    settle();

    // start held high with times=2: done every 3 cycles
    start_pulse(8'd2);
    watch(9, 16'h03FE, fd, nd, bn, ov, dv);
    check("held_done_edges", dv, 32'h0000_0248);
    check("held_done_count", 32'(nd), 32'd3);
    check("held_overlap", 32'(ov), 32'd0);
    settle();

    // times=4, reset asserted between edges k+2 and k+3
    start_pulse(8'd4);
    step();
    step();
    check("rst_mid_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy_now", 32'(busy), 32'd0);
    check("rst_mid_done_now", 32'(done), 32'd0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    watch(10, 16'h0000, fd, nd, bn, ov, dv);
    check("rst_mid_no_done", 32'(nd), 32'd0);
    check("rst_mid_no_busy", 32'(bn), 32'd0);

    // first start after reset honoured immediately
    start_pulse(8'd1);
    check("after_rst_busy", 32'(busy), 32'd1);
    watch(4, 16'h0000, fd, nd, bn, ov, dv);
    check("after_rst_done_edge", 32'(fd), 32'd2);
    settle();

    // full-scale length: no wrap-around
    start_pulse(8'hFF);
    watch(262, 16'h0000, fd, nd, bn, ov, dv);
    check("max_done_edge", 32'(fd), 32'd256);
    check("max_done_count", 32'(nd), 32'd1);
    check("max_busy_cycles", 32'(bn + 1), 32'd255);
    check("max_overlap", 32'(ov), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
